// File: rtl/fu_issue_ctrl_if.sv
// fu_issue_ctrl_if: instruction handshake, function-unit operand/result bus and debug read port.
// Latency: none (wires only).
// Backpressure: INSTR_VALID/INSTR_READY handshake; the FU side has no flow control.
interface fu_issue_ctrl_if #(
   parameter int REG_ADDR_W = 3
);
   logic [31:0]           INSTR;
   logic                  INSTR_VALID;
   logic                  INSTR_READY;
   logic [31:0]           FU_A;
   logic [31:0]           FU_B;
   logic [4:0]            FU_SH;
   logic [4:0]            FU_FS;
   logic [31:0]           FU_F;
   logic                  FU_Z;
   logic                  FU_C;
   logic                  FU_N;
   logic                  FU_V;
   logic                  DONE;
   logic                  ILLEGAL;
   logic [3:0]            STATUS;
   logic [REG_ADDR_W-1:0] RD_ADDR;
   logic [31:0]           RD_DATA;

   // View of the issue controller itself.
   modport slave (
      input  INSTR, INSTR_VALID, FU_F, FU_Z, FU_C, FU_N, FU_V, RD_ADDR,
      output INSTR_READY, FU_A, FU_B, FU_SH, FU_FS, DONE, ILLEGAL, STATUS, RD_DATA
   );

   // View of the environment: instruction source, function unit and debug reader.
   modport master (
      output INSTR, INSTR_VALID, FU_F, FU_Z, FU_C, FU_N, FU_V, RD_ADDR,
      input  INSTR_READY, FU_A, FU_B, FU_SH, FU_FS, DONE, ILLEGAL, STATUS, RD_DATA
   );
endinterface

// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: issues one instruction to a combinational function unit, retires its result to a register file.
// Latency: handshake edge -> ISSUE cycle -> CAPTURE cycle (DONE); one instruction per 3 cycles.
// Backpressure: INSTR_READY is high only in IDLE; INSTR offered at any other time is ignored.
module fu_issue_ctrl #(
   parameter int REG_ADDR_W = 3
) (
   input  logic           CLK,
   input  logic           RESET,
   fu_issue_ctrl_if.slave bus
);
   localparam int NREG = 2 ** REG_ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t      state_q;
   // Latched copy of the instruction: only what is still needed after the handshake.
   logic [2:0]  dr_q;
   logic        legal_q;
   // Registered function-unit drive, non-zero only during ISSUE.
   logic [31:0] fu_a_q;
   logic [31:0] fu_b_q;
   logic [4:0]  fu_sh_q;
   logic [4:0]  fu_fs_q;
   // Function-unit result sampled at the end of ISSUE, committed at the end of CAPTURE.
   logic [31:0] res_q;
   logic [3:0]  flags_q;
   logic        done_q;
   logic        ill_q;
   logic [3:0]  status_q;
   // Register 0 is hard-wired to zero, so it has no storage.
   logic [31:0] regs_q [1:NREG-1];

   logic [31:0] opa_d;
   logic [31:0] opb_d;
   logic [31:0] rd_data_d;
   logic        op_legal_d;
   logic        unused_instr_bits;

   // Instruction bits between the register fields and SH carry no meaning here.
   assign unused_instr_bits = ^bus.INSTR[17:5];

   // Classify the offered opcode as supported or not.
   always_comb begin
      op_legal_d = 1'b0;
      case (bus.INSTR[31:27])
         5'b00000, 5'b00010, 5'b00101, 5'b00111, 5'b01000,
         5'b01010, 5'b01100, 5'b01110, 5'b10000, 5'b10001: op_legal_d = 1'b1;
         default:                                          op_legal_d = 1'b0;
      endcase
   end

   // Operand reads for SA/SB of the offered instruction; register 0 and unimplemented indices read 0.
   always_comb begin
      opa_d = '0;
      opb_d = '0;
      for (int i = 1; i < NREG; i++) begin
         if (32'(bus.INSTR[23:21]) == 32'(i)) opa_d = regs_q[i];
         if (32'(bus.INSTR[20:18]) == 32'(i)) opb_d = regs_q[i];
      end
   end

   // Debug read port; register 0 reads 0.
   always_comb begin
      rd_data_d = '0;
      for (int i = 1; i < NREG; i++) begin
         if (bus.RD_ADDR == REG_ADDR_W'(i)) rd_data_d = regs_q[i];
      end
   end

   // Issue FSM: latches the instruction and operands at the handshake, samples the FU at the end of ISSUE,
   // and raises DONE/ILLEGAL for exactly the CAPTURE cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         dr_q    <= '0;
         legal_q <= 1'b0;
         fu_a_q  <= '0;
         fu_b_q  <= '0;
         fu_sh_q <= '0;
         fu_fs_q <= '0;
         res_q   <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ill_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.INSTR_VALID) begin
                  dr_q    <= bus.INSTR[26:24];
                  legal_q <= op_legal_d;
                  fu_a_q  <= opa_d;
                  fu_b_q  <= opb_d;
                  fu_sh_q <= bus.INSTR[4:0];
                  fu_fs_q <= op_legal_d ? bus.INSTR[31:27] : 5'b00000;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               res_q   <= bus.FU_F;
               flags_q <= {bus.FU_Z, bus.FU_C, bus.FU_N, bus.FU_V};
               fu_a_q  <= '0;
               fu_b_q  <= '0;
               fu_sh_q <= '0;
               fu_fs_q <= '0;
               done_q  <= 1'b1;
               ill_q   <= ~legal_q;
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Commit result and flags when CAPTURE of a legal instruction completes; a reset during CAPTURE
   // therefore drops the write.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
         status_q <= '0;
      end else if (state_q == S_CAPTURE && legal_q) begin
         status_q <= flags_q;
         for (int i = 1; i < NREG; i++) begin
            if (32'(dr_q) == 32'(i)) regs_q[i] <= res_q;
         end
      end
   end

   // Ready follows reset combinationally so it is low throughout reset and high in the first cycle after.
   assign bus.INSTR_READY = (state_q == S_IDLE) && !RESET;
   assign bus.FU_A        = fu_a_q;
   assign bus.FU_B        = fu_b_q;
   assign bus.FU_SH       = fu_sh_q;
   assign bus.FU_FS       = fu_fs_q;
   assign bus.DONE        = done_q;
   assign bus.ILLEGAL     = ill_q;
   assign bus.STATUS      = status_q;
   assign bus.RD_DATA     = rd_data_d;
endmodule

// File: tb/tb_fu_issue_ctrl.sv
// tb_fu_issue_ctrl: directed and randomized instruction streams against a register-array reference model.
// Latency: expects FU drive in the 1st cycle after the handshake and DONE in the 2nd.
// Backpressure: waits (bounded) for INSTR_READY before every instruction.
module tb_fu_issue_ctrl;
   localparam int W = 3;

   logic        CLK;
   logic        RESET;
   int          vectors;
   int          miscompares;
   logic        ovr_en;
   logic [31:0] ovr_val;
   logic [31:0] ref_r [8];
   logic [3:0]  ref_st;
   logic [4:0]  legal_ops [10];

   fu_issue_ctrl_if #(.REG_ADDR_W(W)) bus ();

   fu_issue_ctrl #(.REG_ADDR_W(W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Function-unit behaviour of the environment: {Z,C,N,V,F}. An override forces F for register preloads.
   function automatic logic [35:0] fu_eval(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh, input logic ov, input logic [31:0] ovv);
      logic [32:0] s;
      logic [31:0] f;
      logic        c;
      logic        v;
      s = '0; f = '0; c = 1'b0; v = 1'b0;
      case (fs)
         5'b00000: f = a;
         5'b00010: begin s = {1'b0, a} + {1'b0, b}; f = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (f[31] != a[31]); end
         5'b00101: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; f = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (f[31] != a[31]); end
         5'b00111: begin s = {1'b0, a} + {1'b0, 32'hFFFF_FFFF}; f = s[31:0]; c = s[32]; end
         5'b01000: f = a & b;
         5'b01010: f = a | b;
         5'b01100: f = a ^ b;
         5'b01110: f = ~a;
         5'b10000: f = a >> sh;
         5'b10001: f = a << sh;
         default:  f = '0;
      endcase
      if (ov) begin f = ovv; c = 1'b0; v = 1'b0; end
      return {(f == 32'd0), c, f[31], v, f};
   endfunction

   always_comb begin
      {bus.FU_Z, bus.FU_C, bus.FU_N, bus.FU_V, bus.FU_F} = fu_eval(bus.FU_FS, bus.FU_A, bus.FU_B, bus.FU_SH, ovr_en, ovr_val);
   end

   function automatic bit is_legal(input logic [4:0] op);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 10; i++) if (legal_ops[i] == op) found = 1'b1;
      return found;
   endfunction

   task automatic clear_ref();
      for (int i = 0; i < 8; i++) ref_r[i] = '0;
      ref_st = '0;
   endtask

   // One instruction from handshake to retirement, checked cycle by cycle; abort=1 pulses RESET in CAPTURE.
   task automatic run_instr(input string tag, input logic [4:0] op, input logic [2:0] dr, input logic [2:0] sa,
                            input logic [2:0] sb, input logic [4:0] sh, input logic ov, input logic [31:0] ovv,
                            input logic abort);
      logic [35:0] r;
      logic [4:0]  efs;
      logic        leg;
      logic [31:0] ea;
      logic [31:0] eb;
      int          n;
      leg = is_legal(op);
      efs = leg ? op : 5'd0;
      ea  = ref_r[sa];
      eb  = ref_r[sb];
      r   = fu_eval(efs, ea, eb, sh, ov, ovv);
      n = 0;
      while (bus.INSTR_READY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      vectors++; if (bus.INSTR_READY !== 1'b1) begin miscompares++; $display("FAIL %s ready_wait: got %b want 1", tag, bus.INSTR_READY); end
      bus.INSTR       = {op, dr, sa, sb, 13'($urandom), sh};
      bus.INSTR_VALID = 1'b1;
      ovr_en          = ov;
      ovr_val         = ovv;
      @(posedge CLK); #1;
      // Keep offering garbage while busy: it must be ignored.
      bus.INSTR = $urandom();
      @(negedge CLK);
      vectors++; if (bus.FU_A !== ea) begin miscompares++; $display("FAIL %s issue_fu_a: got %h want %h", tag, bus.FU_A, ea); end
      vectors++; if (bus.FU_B !== eb) begin miscompares++; $display("FAIL %s issue_fu_b: got %h want %h", tag, bus.FU_B, eb); end
      vectors++; if (bus.FU_SH !== sh) begin miscompares++; $display("FAIL %s issue_fu_sh: got %h want %h", tag, bus.FU_SH, sh); end
      vectors++; if (bus.FU_FS !== efs) begin miscompares++; $display("FAIL %s issue_fu_fs: got %b want %b", tag, bus.FU_FS, efs); end
      vectors++; if (bus.DONE !== 1'b0 || bus.INSTR_READY !== 1'b0) begin miscompares++; $display("FAIL %s issue_done_ready: got %b%b want 00", tag, bus.DONE, bus.INSTR_READY); end
      bus.RD_ADDR = dr;
      @(negedge CLK);
      bus.INSTR_VALID = 1'b0;
      if (abort) begin
         RESET = 1'b1; #1;
         vectors++; if (bus.DONE !== 1'b0 || bus.ILLEGAL !== 1'b0) begin miscompares++; $display("FAIL %s abort_done_ill: got %b%b want 00", tag, bus.DONE, bus.ILLEGAL); end
         vectors++; if (bus.INSTR_READY !== 1'b0) begin miscompares++; $display("FAIL %s abort_ready: got %b want 0", tag, bus.INSTR_READY); end
         vectors++; if (bus.FU_A !== 32'd0 || bus.FU_FS !== 5'd0) begin miscompares++; $display("FAIL %s abort_fu: got %h/%b want 0/0", tag, bus.FU_A, bus.FU_FS); end
         @(negedge CLK);
         RESET = 1'b0; #1;
         vectors++; if (bus.INSTR_READY !== 1'b1) begin miscompares++; $display("FAIL %s ready_after_reset: got %b want 1", tag, bus.INSTR_READY); end
         ovr_en = 1'b0;
         clear_ref();
         return;
      end
      vectors++; if (bus.DONE !== 1'b1) begin miscompares++; $display("FAIL %s capture_done: got %b want 1", tag, bus.DONE); end
      vectors++; if (bus.ILLEGAL !== !leg) begin miscompares++; $display("FAIL %s capture_illegal: got %b want %b", tag, bus.ILLEGAL, !leg); end
      vectors++; if (bus.FU_A !== 32'd0 || bus.FU_B !== 32'd0 || bus.FU_SH !== 5'd0 || bus.FU_FS !== 5'd0) begin
         miscompares++; $display("FAIL %s capture_fu_zero: got %h %h %h %h want all 0", tag, bus.FU_A, bus.FU_B, bus.FU_SH, bus.FU_FS); end
      if (leg) begin
         if (dr != 3'd0) ref_r[dr] = r[31:0];
         ref_st = r[35:32];
      end
      @(negedge CLK);
      ovr_en = 1'b0;
      vectors++; if (bus.DONE !== 1'b0 || bus.ILLEGAL !== 1'b0) begin miscompares++; $display("FAIL %s idle_pulse_end: got %b%b want 00", tag, bus.DONE, bus.ILLEGAL); end
      vectors++; if (bus.INSTR_READY !== 1'b1) begin miscompares++; $display("FAIL %s idle_ready: got %b want 1", tag, bus.INSTR_READY); end
      vectors++; if (bus.STATUS !== ref_st) begin miscompares++; $display("FAIL %s status: got %b want %b", tag, bus.STATUS, ref_st); end
      vectors++; if (bus.RD_DATA !== ref_r[dr]) begin miscompares++; $display("FAIL %s rd_data: got %h want %h", tag, bus.RD_DATA, ref_r[dr]); end
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         bus.RD_ADDR = 3'(i);
         #1;
         vectors++; if (bus.RD_DATA !== ref_r[i]) begin miscompares++; $display("FAIL %s reg%0d: got %h want %h", tag, i, bus.RD_DATA, ref_r[i]); end
      end
      vectors++; if (bus.STATUS !== ref_st) begin miscompares++; $display("FAIL %s status: got %b want %b", tag, bus.STATUS, ref_st); end
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      #2;
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      vectors++; if (bus.INSTR_READY !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", bus.INSTR_READY); end
      vectors++; if (bus.DONE !== 1'b0 || bus.ILLEGAL !== 1'b0) begin miscompares++; $display("FAIL reset_done_ill: got %b%b want 00", bus.DONE, bus.ILLEGAL); end
      vectors++; if (bus.FU_A !== 32'd0 || bus.FU_B !== 32'd0 || bus.FU_SH !== 5'd0 || bus.FU_FS !== 5'd0) begin
         miscompares++; $display("FAIL reset_fu: got %h %h %h %h want all 0", bus.FU_A, bus.FU_B, bus.FU_SH, bus.FU_FS); end
      vectors++; if (bus.STATUS !== 4'd0 || bus.RD_DATA !== 32'd0) begin miscompares++; $display("FAIL reset_status_rd: got %b %h want 0 0", bus.STATUS, bus.RD_DATA); end
      RESET = 1'b0;
      #1;
      vectors++; if (bus.INSTR_READY !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", bus.INSTR_READY); end
      clear_ref();
   endtask

   task automatic test_add();
      run_instr("preload_r1", 5'b00010, 3'd1, 3'd0, 3'd0, 5'd0, 1'b1, 32'd5, 1'b0);
      run_instr("preload_r2", 5'b00010, 3'd2, 3'd0, 3'd0, 5'd0, 1'b1, 32'd3, 1'b0);
      run_instr("add", 5'b00010, 3'd3, 3'd1, 3'd2, 5'd0, 1'b0, 32'd0, 1'b0);
      bus.RD_ADDR = 3'd3; #1;
      vectors++; if (bus.RD_DATA !== 32'd8) begin miscompares++; $display("FAIL add_r3: got %h want 8", bus.RD_DATA); end
   endtask

   task automatic test_sub();
      run_instr("sub", 5'b00101, 3'd4, 3'd2, 3'd1, 5'd0, 1'b0, 32'd0, 1'b0);
      bus.RD_ADDR = 3'd4; #1;
      vectors++; if (bus.RD_DATA !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sub_r4: got %h want fffffffe", bus.RD_DATA); end
      vectors++; if (bus.STATUS[1] !== 1'b1) begin miscompares++; $display("FAIL sub_status_n: got %b want 1", bus.STATUS[1]); end
   endtask

   task automatic test_back_to_back();
      run_instr("lsl", 5'b10001, 3'd5, 3'd1, 3'd0, 5'd4, 1'b0, 32'd0, 1'b0);
      run_instr("lsr", 5'b10000, 3'd6, 3'd5, 3'd0, 5'd2, 1'b0, 32'd0, 1'b0);
      bus.RD_ADDR = 3'd5; #1;
      vectors++; if (bus.RD_DATA !== 32'h50) begin miscompares++; $display("FAIL lsl_r5: got %h want 50", bus.RD_DATA); end
      bus.RD_ADDR = 3'd6; #1;
      vectors++; if (bus.RD_DATA !== 32'h14) begin miscompares++; $display("FAIL lsr_r6: got %h want 14", bus.RD_DATA); end
   endtask

   task automatic test_illegal();
      run_instr("illegal", 5'b11111, 3'd3, 3'd1, 3'd2, 5'd7, 1'b0, 32'd0, 1'b0);
      check_all_regs("illegal_regs");
   endtask

   task automatic test_dr_zero();
      run_instr("dr_zero", 5'b00010, 3'd0, 3'd4, 3'd2, 5'd0, 1'b0, 32'd0, 1'b0);
      bus.RD_ADDR = 3'd0; #1;
      vectors++; if (bus.RD_DATA !== 32'd0) begin miscompares++; $display("FAIL dr_zero_r0: got %h want 0", bus.RD_DATA); end
      vectors++; if (bus.STATUS !== 4'b0100) begin miscompares++; $display("FAIL dr_zero_status: got %b want 0100", bus.STATUS); end
   endtask

   task automatic test_reset_in_capture();
      run_instr("abort", 5'b00010, 3'd7, 3'd1, 3'd2, 5'd0, 1'b0, 32'd0, 1'b1);
      check_all_regs("abort_regs");
   endtask

   task automatic test_random();
      logic [4:0] op;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 9)];
         else op = 5'($urandom);
         run_instr("random", op, 3'($urandom), 3'($urandom), 3'($urandom), 5'($urandom),
                   ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, $urandom(), 1'b0);
      end
      check_all_regs("random_regs");
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      ovr_en          = 1'b0;
      ovr_val         = '0;
      bus.INSTR       = '0;
      bus.INSTR_VALID = 1'b0;
      bus.RD_ADDR     = '0;
      legal_ops[0] = 5'b00000; legal_ops[1] = 5'b00010; legal_ops[2] = 5'b00101; legal_ops[3] = 5'b01000;
      legal_ops[4] = 5'b01010; legal_ops[5] = 5'b01100; legal_ops[6] = 5'b01110; legal_ops[7] = 5'b10000;
      legal_ops[8] = 5'b10001; legal_ops[9] = 5'b00111;
      clear_ref();
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_illegal();
      test_dr_zero();
      test_reset_in_capture();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
